// File: rtl/exu_pkg.sv
// Shared definitions for the execute stage: opcode encoding, control bundle,
// forwarding selects and divider FSM states.
package exu_pkg;

  // Bit 5 selects the immediate as operand B; bits [4:0] name the base operation.
  typedef enum logic [5:0] {
    OpAdd    = 6'h00, OpSub    = 6'h01, OpSll    = 6'h02, OpSlt    = 6'h03,
    OpSltu   = 6'h04, OpXor    = 6'h05, OpSrl    = 6'h06, OpSra    = 6'h07,
    OpOr     = 6'h08, OpAnd    = 6'h09, OpAddw   = 6'h0A, OpSubw   = 6'h0B,
    OpSllw   = 6'h0C, OpSrlw   = 6'h0D, OpSraw   = 6'h0E, OpMul    = 6'h0F,
    OpMulh   = 6'h10, OpMulhsu = 6'h11, OpMulhu  = 6'h12, OpMulw   = 6'h13,
    OpDiv    = 6'h14, OpDivu   = 6'h15, OpRem    = 6'h16, OpRemu   = 6'h17,
    OpDivw   = 6'h18, OpDivuw  = 6'h19, OpRemw   = 6'h1A, OpRemuw  = 6'h1B,
    OpAddi   = 6'h20, OpSlli   = 6'h22, OpSlti   = 6'h23, OpSltiu  = 6'h24,
    OpXori   = 6'h25, OpSrli   = 6'h26, OpSrai   = 6'h27, OpOri    = 6'h28,
    OpAndi   = 6'h29, OpAddiw  = 6'h2A, OpSlliw  = 6'h2C, OpSrliw  = 6'h2D,
    OpSraiw  = 6'h2E
  } alu_op_e;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_or_reg;
    logic       pc_src;
    logic       reg_write;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic [4:0] dest_register;
  } ctrl_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  typedef enum logic [1:0] {StDivIdle, StDivBusy, StDivFix} div_state_e;

  function automatic logic is_word_op(input alu_op_e op);
    case (op)
      OpAddw, OpSubw, OpSllw, OpSrlw, OpSraw, OpMulw,
      OpDivw, OpDivuw, OpRemw, OpRemuw: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    case (op)
      OpDiv, OpDivu, OpRem, OpRemu, OpDivw, OpDivuw, OpRemw, OpRemuw: return 1'b1;
      default:                                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_unit_mdu_divider.sv
// Iterative restoring divider: magnitudes are divided one bit per cycle, then
// sign correction and word sign-extension are applied in the fix state.
module mdu_divider
  import exu_pkg::*;
#(
  parameter int unsigned Width  = 64,
  parameter int unsigned Cycles = Width
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             rem_i,
  input  logic             word_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             idle_o,
  output logic             done_o,
  output logic [Width-1:0] result_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  function automatic logic [Width-1:0] sext32(input logic [31:0] v);
    return Width'($signed(v));
  endfunction

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d, rem_sel_q, rem_sel_d, word_q, word_d;

  logic [Width-1:0] dvd_ext, dvs_ext, dvd_mag, dvs_mag, min_ext, q_fix, r_fix, res;
  logic             dvd_neg, dvs_neg, div_zero, overflow;
  logic [Width:0]   shifted, diff;

  always_comb begin
    dvd_ext  = word_i ? (signed_i ? sext32(dividend_i[31:0]) : Width'(dividend_i[31:0]))
                      : dividend_i;
    dvs_ext  = word_i ? (signed_i ? sext32(divisor_i[31:0]) : Width'(divisor_i[31:0]))
                      : divisor_i;
    dvd_neg  = signed_i & dvd_ext[Width-1];
    dvs_neg  = signed_i & dvs_ext[Width-1];
    dvd_mag  = dvd_neg ? -dvd_ext : dvd_ext;
    dvs_mag  = dvs_neg ? -dvs_ext : dvs_ext;
    min_ext  = word_i ? sext32(32'h8000_0000) : {1'b1, {(Width-1){1'b0}}};
    div_zero = (dvs_ext == '0);
    overflow = signed_i && (dvd_ext == min_ext) && (dvs_ext == '1);
    shifted  = {rem_q, quo_q[Width-1]};
    diff     = shifted - {1'b0, dvsr_q};

    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    rem_sel_d = rem_sel_q;
    word_d    = word_q;

    unique case (state_q)
      StDivIdle: begin
        if (start_i) begin
          rem_sel_d = rem_i;
          word_d    = word_i;
          neg_q_d   = 1'b0;
          neg_r_d   = 1'b0;
          if (div_zero) begin
            quo_d   = '1;
            rem_d   = dvd_ext;
            state_d = StDivFix;
          end else if (overflow) begin
            quo_d   = dvd_ext;
            rem_d   = '0;
            state_d = StDivFix;
          end else begin
            // Word operands sit in the top half so the MSB-first loop sees them first.
            quo_d   = word_i ? (dvd_mag << 32) : dvd_mag;
            rem_d   = '0;
            dvsr_d  = dvs_mag;
            neg_q_d = dvd_neg ^ dvs_neg;
            neg_r_d = dvd_neg;
            count_d = word_i ? CntW'(32) : CntW'(Cycles);
            state_d = StDivBusy;
          end
        end
      end
      StDivBusy: begin
        if (count_q == '0) begin
          state_d = StDivFix;
        end else begin
          if (!diff[Width]) begin
            rem_d = diff[Width-1:0];
            quo_d = {quo_q[Width-2:0], 1'b1};
          end else begin
            rem_d = shifted[Width-1:0];
            quo_d = {quo_q[Width-2:0], 1'b0};
          end
          count_d = count_q - CntW'(1);
        end
      end
      StDivFix: state_d = StDivIdle;
      default:  state_d = StDivIdle;
    endcase

    if (flush_i) state_d = StDivIdle;
  end

  always_comb begin
    q_fix    = neg_q_q ? -quo_q : quo_q;
    r_fix    = neg_r_q ? -rem_q : rem_q;
    res      = rem_sel_q ? r_fix : q_fix;
    result_o = word_q ? sext32(res[31:0]) : res;
    done_o   = (state_q == StDivFix);
    idle_o   = (state_q == StDivIdle);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StDivIdle;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      rem_sel_q <= rem_sel_d;
      word_q    <= word_d;
    end
  end

endmodule

// File: rtl/exec_unit_mdu.sv
// Execute stage with valid/accept handshake: forwarding muxes, ALU, multiplier,
// branch target and registered outputs; divides are handed to mdu_divider.
module exec_unit_mdu
  import exu_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned SHAMT_WIDTH    = $clog2(BUS_DATA_WIDTH),
  parameter int unsigned IMM_SHIFT      = 1,
  parameter int unsigned DIV_CYCLES     = BUS_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inValid,
  output logic                      outAccept,
  input  logic                      inFlush,
  input  logic [BUS_DATA_WIDTH-1:0] inPc,
  input  logic [BUS_DATA_WIDTH-1:0] inDataReg1,
  input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
  input  logic [BUS_DATA_WIDTH-1:0] inImm,
  input  logic [5:0]                inAluControl,
  input  logic [1:0]                inForwardA,
  input  logic [1:0]                inForwardB,
  input  logic [BUS_DATA_WIDTH-1:0] inResultEx,
  input  logic [BUS_DATA_WIDTH-1:0] inResultMem,
  input  ctrl_t                     inCtrl,
  input  logic                      inAccept,
  output logic                      outValid,
  output logic [BUS_DATA_WIDTH-1:0] outResult,
  output logic                      outZero,
  output logic [BUS_DATA_WIDTH-1:0] outAddrJump,
  output logic [BUS_DATA_WIDTH-1:0] outDataReg2,
  output ctrl_t                     outCtrl
);

  localparam int unsigned W = BUS_DATA_WIDTH;

  function automatic logic [W-1:0] sext32(input logic [31:0] v);
    return W'($signed(v));
  endfunction

  alu_op_e            base;
  logic [W-1:0]       op_a, fwd_b, op_b, alu_res, div_res;
  logic [31:0]        a_lo, b_lo;
  logic               mul_a_sgn, mul_b_sgn, is_div, take, div_idle, div_done;
  logic signed [W:0]  mul_a, mul_b;
  logic signed [2*W+1:0] prod;
  logic               unused_prod;

  logic         valid_q, valid_d, zero_q, zero_d;
  logic [W-1:0] result_q, result_d, addr_q, addr_d, data2_q, data2_d;
  ctrl_t        ctrl_q, ctrl_d;

  assign base = alu_op_e'({1'b0, inAluControl[4:0]});

  always_comb begin
    case (inForwardA)
      FWD_MEM: op_a = inResultMem;
      FWD_EX:  op_a = inResultEx;
      default: op_a = inDataReg1;
    endcase
    case (inForwardB)
      FWD_MEM: fwd_b = inResultMem;
      FWD_EX:  fwd_b = inResultEx;
      default: fwd_b = inDataReg2;
    endcase
  end

  assign op_b = inAluControl[5] ? inImm : fwd_b;
  assign a_lo = op_a[31:0];
  assign b_lo = op_b[31:0];

  // One (W+1)x(W+1) signed multiply covers all four signedness combinations.
  assign mul_a_sgn   = (base == OpMulh) || (base == OpMulhsu);
  assign mul_b_sgn   = (base == OpMulh);
  assign mul_a       = {mul_a_sgn & op_a[W-1], op_a};
  assign mul_b       = {mul_b_sgn & op_b[W-1], op_b};
  assign prod        = mul_a * mul_b;
  assign unused_prod = ^prod[2*W+1:2*W];

  always_comb begin
    alu_res = '0;
    case (base)
      OpAdd:    alu_res = op_a + op_b;
      OpSub:    alu_res = op_a - op_b;
      OpSll:    alu_res = op_a << op_b[SHAMT_WIDTH-1:0];
      OpSlt:    alu_res = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OpSltu:   alu_res = {{(W-1){1'b0}}, op_a < op_b};
      OpXor:    alu_res = op_a ^ op_b;
      OpSrl:    alu_res = op_a >> op_b[SHAMT_WIDTH-1:0];
      OpSra:    alu_res = $signed(op_a) >>> op_b[SHAMT_WIDTH-1:0];
      OpOr:     alu_res = op_a | op_b;
      OpAnd:    alu_res = op_a & op_b;
      OpAddw:   alu_res = sext32(a_lo + b_lo);
      OpSubw:   alu_res = sext32(a_lo - b_lo);
      OpSllw:   alu_res = sext32(a_lo << b_lo[4:0]);
      OpSrlw:   alu_res = sext32(a_lo >> b_lo[4:0]);
      OpSraw:   alu_res = sext32($signed(a_lo) >>> b_lo[4:0]);
      OpMul:    alu_res = prod[W-1:0];
      OpMulh, OpMulhsu, OpMulhu: alu_res = prod[2*W-1:W];
      OpMulw:   alu_res = sext32(prod[31:0]);
      default:  alu_res = '0;
    endcase
  end

  assign is_div    = is_div_op(base);
  assign outAccept = !inFlush && div_idle && (!valid_q || inAccept);
  assign take      = inValid && outAccept;

  mdu_divider #(
    .Width  (W),
    .Cycles (DIV_CYCLES)
  ) u_divider (
    .clk_i      (clk),
    .reset_i    (reset),
    .flush_i    (inFlush),
    .start_i    (take && is_div),
    .signed_i   ((base == OpDiv) || (base == OpRem) || (base == OpDivw) || (base == OpRemw)),
    .rem_i      ((base == OpRem) || (base == OpRemu) || (base == OpRemw) || (base == OpRemuw)),
    .word_i     (is_word_op(base) && (W > 32)),
    .dividend_i (op_a),
    .divisor_i  (op_b),
    .idle_o     (div_idle),
    .done_o     (div_done),
    .result_o   (div_res)
  );

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    zero_d   = zero_q;
    addr_d   = addr_q;
    data2_d  = data2_q;
    ctrl_d   = ctrl_q;
    if (inFlush) begin
      valid_d = 1'b0;
    end else begin
      if (valid_q && inAccept) valid_d = 1'b0;
      if (take) begin
        ctrl_d  = inCtrl;
        addr_d  = inPc + (inImm << IMM_SHIFT);
        data2_d = fwd_b;
        if (!is_div) begin
          valid_d  = 1'b1;
          result_d = alu_res;
          zero_d   = (alu_res == '0);
        end
      end
      // Divider completes only while the output stage is empty.
      if (div_done) begin
        valid_d  = 1'b1;
        result_d = div_res;
        zero_d   = (div_res == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      addr_q   <= '0;
      data2_q  <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      addr_q   <= addr_d;
      data2_q  <= data2_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign outValid    = valid_q;
  assign outResult   = result_q;
  assign outZero     = zero_q;
  assign outAddrJump = addr_q;
  assign outDataReg2 = data2_q;
  assign outCtrl     = ctrl_q;

endmodule

// File: doc/exec_unit_mdu.md
Name: exec_unit_mdu

Overview:
- Parametrised successor to the single-cycle execute stage. Sits between decode/register-read and the memory stage.
- Adds a valid/accept handshake on both sides, back-pressure and flush support.
- Adds correct 64/32-bit (W) semantics, an iterative radix-2 divider and full-width high-half multiplies.
- Forwarding muxes and branch-target generation stay in this block. All results are registered.

Parameters:
- BUS_DATA_WIDTH, 64, operand/result width (32 or 64).
- SHAMT_WIDTH, $clog2(BUS_DATA_WIDTH), shift-amount bits taken from operand 2 / imm.
- IMM_SHIFT, 1, left shift applied to imm for branch target.
- DIV_CYCLES, BUS_DATA_WIDTH, iterations of the divider loop.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inValid  in  1  upstream presents an op
- outAccept  out  1  block can take an op this cycle
- inFlush  in  1  kill in-flight op and output
- inPc  in  BUS_DATA_WIDTH  PC of op
- inDataReg1/inDataReg2  in  BUS_DATA_WIDTH  register operands
- inImm  in  BUS_DATA_WIDTH  sign-extended immediate
- inAluControl  in  6  op code (shared package encoding)
- inForwardA/inForwardB  in  2  00 reg, 01 mem, 10 ex, 11 reg
- inResultEx/inResultMem  in  BUS_DATA_WIDTH  forwarded values
- inCtrl  in  ctrl_t  branch/memRead/memWrite/memOrReg/pcSrc/regWrite/loadType/storeType/destRegister bundle
- inAccept  in  1  downstream takes output
- outValid  out  1  output holds a result
- outResult  out  BUS_DATA_WIDTH  result
- outZero  out  1  result == 0
- outAddrJump  out  BUS_DATA_WIDTH  inPc + (inImm << IMM_SHIFT)
- outDataReg2  out  BUS_DATA_WIDTH  forwarded operand 2 (store data)
- outCtrl  out  ctrl_t  registered control bundle

Behaviour:
- Reset: outValid=0, all data/ctrl outputs 0, FSM=IDLE, outAccept=1 in the cycle after reset deasserts.
- Operand mux: combinational, fully specified. 11 selects the register value. Store data uses the forwarded operand 2.
- Handshake:
  - outAccept = (state==IDLE) && (!outValid || inAccept).
  - An op is taken when inValid && outAccept.
  - While outValid && !inAccept, every output holds stable.
- Single-cycle ops (ALU, shifts, compares, mul/mulh/mulhsu/mulhu/mulw) produce outValid at the next edge, latency 1.
- mulh* returns bits [2W-1:W] of the 2W-bit product, with signed/unsigned/signed-unsigned operand treatment per op.
- 64-bit shifts use SHAMT_WIDTH bits. W shifts use 5 bits.
- W ops compute on the low 32 bits and sign-extend bit 31 to BUS_DATA_WIDTH. When BUS_DATA_WIDTH==32, W ops equal their base ops.
- slt/sltu result is 1/0. outZero = (outResult==0), the true-zero polarity.
- Divider FSM for div/divu/rem/remu/divw/divuw/remw/remuw:
  - IDLE: on accept, latch operands, signs and ctrl. Go to DIV_BUSY with count=DIV_CYCLES (32 for W ops).
  - DIV_BUSY: one restoring shift-subtract step per cycle. When count reaches 0, go to DIV_FIX.
  - DIV_FIX: apply sign correction and write the output regs, outValid=1, then go to IDLE. Total latency = count+2 cycles from accept.
- Divide corner cases:
  - Divide by zero: quotient = all ones, remainder = dividend. Takes 1 cycle; skip BUSY and go straight to FIX.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0. Same 1-cycle path.
- Unknown opcode: result 0, outValid still asserted, ctrl passed through.
- inFlush (priority over everything except reset):
  - FSM goes to IDLE and outValid=0 at the next edge.
  - An op presented in the flush cycle is dropped.
  - outAccept=0 in the flush cycle.
- Simultaneous cases:
  - Accept and output drain in the same cycle is legal for single-cycle ops, giving back-to-back throughput of 1/cycle.
  - A divide accepted while outValid is draining starts immediately.

Decomposition:
- Shared package exu_pkg holds:
  - the alu_op_e enum (6-bit encodings);
  - the ctrl_t packed struct;
  - the forward-select localparams FWD_REG/FWD_MEM/FWD_EX;
  - helper function is_word_op().
- One sub-module: mdu_divider (iterative, start/done handshake, signed/unsigned/word modes). The top level keeps the ALU, multiplier, muxes and output regs.

Test Plan:
- Reset high 2 cycles -> outValid=0, outResult=0, outAccept=1 after release.
- add 5+(-7), then sub 3-3 back-to-back with inAccept=1 -> results 0xFFFF_FFFF_FFFF_FFFE (zero=0) then 0 (zero=1). outValid on consecutive cycles.
- addw 0x7FFF_FFFF+1 -> 0xFFFF_FFFF_8000_0000. mulhu 0xFFFF_FFFF_FFFF_FFFF*2 -> 1. sll by 40 of 1 -> 0x100_0000_0000.
- div -20/3 -> quotient -6 after 66 cycles (DIV_CYCLES+2), outAccept=0 throughout. rem -> -2. divu x/0 -> all ones. div MIN/-1 -> MIN. remw by 0 -> dividend sign-extended.
- inForwardA=10 with inResultEx=9, inDataReg1=1, addi imm 1 -> 10. inAccept held 0 for 3 cycles -> outputs stable and outAccept=0.
- Flush asserted mid-divide (cycle 10) -> outValid never rises for that op. Next add is accepted the cycle after the flush and completes normally.
